// File: rtl/branch_resolve_unit_if.sv
// Handshake and payload bundle for branch_resolve_unit.
//   master : issue side (execute-stage mux) plus result consumer (fetch redirect)
//   slave  : branch_resolve_unit
// Request : Flush, In_Valid/In_Ready, Read_Reg_Data_1/2, Branch_Pc, Branch_Imm,
//           Branch_Funct3, Pred_Taken
// Result  : Out_Valid/Out_Ready, Branch_Taken, Branch_Target, Mispredict, Illegal_Funct3
// Optional: BRANCH_STATS_EN adds Stat_Branches, Stat_Taken, Stat_Mispredicts.
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IMM_WIDTH = 13
);
    logic                 Flush;
    logic                 In_Valid;
    logic                 In_Ready;
    logic [XLEN-1:0]      Read_Reg_Data_1;
    logic [XLEN-1:0]      Read_Reg_Data_2;
    logic [XLEN-1:0]      Branch_Pc;
    logic [IMM_WIDTH-1:0] Branch_Imm;
    logic [2:0]           Branch_Funct3;
    logic                 Pred_Taken;
    logic                 Out_Valid;
    logic                 Out_Ready;
    logic                 Branch_Taken;
    logic [XLEN-1:0]      Branch_Target;
    logic                 Mispredict;
    logic                 Illegal_Funct3;
`ifdef BRANCH_STATS_EN
    logic [31:0]          Stat_Branches;
    logic [31:0]          Stat_Taken;
    logic [31:0]          Stat_Mispredicts;
`endif

    modport master (
`ifdef BRANCH_STATS_EN
        input  Stat_Branches, Stat_Taken, Stat_Mispredicts,
`endif
        output Flush, In_Valid, Read_Reg_Data_1, Read_Reg_Data_2, Branch_Pc,
               Branch_Imm, Branch_Funct3, Pred_Taken, Out_Ready,
        input  In_Ready, Out_Valid, Branch_Taken, Branch_Target, Mispredict,
               Illegal_Funct3
    );

    modport slave (
`ifdef BRANCH_STATS_EN
        output Stat_Branches, Stat_Taken, Stat_Mispredicts,
`endif
        input  Flush, In_Valid, Read_Reg_Data_1, Read_Reg_Data_2, Branch_Pc,
               Branch_Imm, Branch_Funct3, Pred_Taken, Out_Ready,
        output In_Ready, Out_Valid, Branch_Taken, Branch_Target, Mispredict,
               Illegal_Funct3
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered RV32/RV64 conditional-branch resolver with a one-entry result register.
// Ports:
//   Clk     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : branch_resolve_unit_if.slave (request, result and optional stats)
// Optional feature: define BRANCH_STATS_EN to add saturating 32-bit counters of
// consumed branches, taken branches and mispredicts.
module branch_resolve_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IMM_WIDTH = 13
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    branch_resolve_unit_if.slave  bus
);

    localparam int unsigned SEXT_W = XLEN - IMM_WIDTH;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mispredict;
        logic            illegal;
    } result_t;

    result_t         res_c;
    result_t         res_d;
    result_t         res_q;
    logic            out_valid_d;
    logic            out_valid_q;
    logic            capture_c;
    logic            consume_c;
    logic            eq_c;
    logic            lt_s_c;
    logic            lt_u_c;
    logic [XLEN-1:0] imm_sext_c;

    // Ready whenever the result register is empty or being drained this cycle.
    assign bus.In_Ready = !out_valid_q || bus.Out_Ready;

    // Resolve the incoming branch combinationally; only the result is registered.
    always_comb begin
        res_c      = '0;
        eq_c       = (bus.Read_Reg_Data_1 == bus.Read_Reg_Data_2);
        lt_s_c     = ($signed(bus.Read_Reg_Data_1) < $signed(bus.Read_Reg_Data_2));
        lt_u_c     = (bus.Read_Reg_Data_1 < bus.Read_Reg_Data_2);
        imm_sext_c = {{SEXT_W{bus.Branch_Imm[IMM_WIDTH-1]}}, bus.Branch_Imm};

        unique case (bus.Branch_Funct3)
            F3_BEQ:  res_c.taken = eq_c;
            F3_BNE:  res_c.taken = !eq_c;
            F3_BLT:  res_c.taken = lt_s_c;
            F3_BGE:  res_c.taken = !lt_s_c;
            F3_BLTU: res_c.taken = lt_u_c;
            F3_BGEU: res_c.taken = !lt_u_c;
            default: res_c.illegal = 1'b1;
        endcase

        res_c.target     = res_c.taken ? (bus.Branch_Pc + imm_sext_c)
                                       : (bus.Branch_Pc + XLEN'(4));
        res_c.mispredict = (res_c.taken != bus.Pred_Taken);
    end

    // Handshake and result-register next state; flush beats capture and consume.
    always_comb begin
        capture_c   = bus.In_Valid && bus.In_Ready && !bus.Flush;
        consume_c   = out_valid_q && bus.Out_Ready && !bus.Flush;
        out_valid_d = out_valid_q;
        res_d       = res_q;

        if (bus.Flush) begin
            out_valid_d = 1'b0;
        end else if (capture_c) begin
            out_valid_d = 1'b1;
        end else if (consume_c) begin
            out_valid_d = 1'b0;
        end

        if (capture_c) begin
            res_d = res_c;
        end
    end

    // Result register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    assign bus.Out_Valid      = out_valid_q;
    assign bus.Branch_Taken   = res_q.taken;
    assign bus.Branch_Target  = res_q.target;
    assign bus.Mispredict     = res_q.mispredict;
    assign bus.Illegal_Funct3 = res_q.illegal;

`ifdef BRANCH_STATS_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] stat_branches_d;
    logic [CNT_W-1:0] stat_branches_q;
    logic [CNT_W-1:0] stat_taken_d;
    logic [CNT_W-1:0] stat_taken_q;
    logic [CNT_W-1:0] stat_mispredicts_d;
    logic [CNT_W-1:0] stat_mispredicts_q;

    // Saturating counters, advanced only when a result leaves the unit.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_taken_d       = stat_taken_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (consume_c) begin
            if (stat_branches_q != '1) begin
                stat_branches_d = stat_branches_q + CNT_W'(1);
            end
            if (res_q.taken && (stat_taken_q != '1)) begin
                stat_taken_d = stat_taken_q + CNT_W'(1);
            end
            if (res_q.mispredict && (stat_mispredicts_q != '1)) begin
                stat_mispredicts_d = stat_mispredicts_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stat_branches_q    <= '0;
            stat_taken_q       <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_taken_q       <= stat_taken_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign bus.Stat_Branches    = stat_branches_q;
    assign bus.Stat_Taken       = stat_taken_q;
    assign bus.Stat_Mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (XLEN=32): the driver pushes the
// reference-model result of every accepted request, the monitor pops and
// compares whenever a result is presented.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        misp;
        logic        ill;
    } exp_t;

    logic Clk;
    logic Reset_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   rdy_mode = 0;          // 0: always ready, 1: random, 2: stalled
    exp_t exp_q[$];
    int   st_br = 0;
    int   st_tk = 0;
    int   st_mp = 0;

    branch_resolve_unit_if #(.XLEN(32), .IMM_WIDTH(13)) bus ();

    branch_resolve_unit #(.XLEN(32), .IMM_WIDTH(13)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model from the architectural rules using wide integer arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [12:0] imm,
                                   input logic [2:0] f3, input logic pred);
        longint ua, ub, sa, sb, si;
        logic   t;
        exp_t   e;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[31] ? ua - (longint'(1) << 32) : ua;
        sb = b[31] ? ub - (longint'(1) << 32) : ub;
        si = imm[12] ? longint'(imm) - 8192 : longint'(imm);
        case (f3)
            3'd0: t = (ua == ub);
            3'd1: t = (ua != ub);
            3'd4: t = (sa < sb);
            3'd5: t = (sa >= sb);
            3'd6: t = (ua < ub);
            3'd7: t = (ua >= ub);
            default: t = 1'b0;
        endcase
        e.taken  = t;
        e.ill    = (f3 == 3'd2) || (f3 == 3'd3);
        e.target = t ? 32'(longint'(pc) + si) : 32'(longint'(pc) + 4);
        e.misp   = (t != pred);
        return e;
    endfunction

    // Consumer readiness, changed just after each rising edge.
    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0:       bus.Out_Ready = 1'b1;
            1:       bus.Out_Ready = ($urandom_range(0, 3) != 0);
            default: bus.Out_Ready = 1'b0;
        endcase
    end

    // Monitor: compare the presented result against the scoreboard head.
    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("in_ready", 64'(bus.In_Ready), 64'(!bus.Out_Valid || bus.Out_Ready));
            if (bus.Out_Valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 64'(bus.Out_Valid), 64'(0));
                end else begin
                    chk("taken",   64'(bus.Branch_Taken),   64'(exp_q[0].taken));
                    chk("target",  64'(bus.Branch_Target),  64'(exp_q[0].target));
                    chk("misp",    64'(bus.Mispredict),     64'(exp_q[0].misp));
                    chk("illegal", 64'(bus.Illegal_Funct3), 64'(exp_q[0].ill));
                    if (bus.Out_Ready && !bus.Flush) begin
                        st_br++;
                        if (exp_q[0].taken) st_tk++;
                        if (exp_q[0].misp)  st_mp++;
                        void'(exp_q.pop_front());
                    end
                end
            end else if (exp_q.size() != 0) begin
                chk("lost_result", 64'(exp_q.size()), 64'(0));
            end
        end
    end

    // One cycle: inputs already driven at posedge+1; record acceptance after the monitor.
    task automatic step(output bit acc);
        @(negedge Clk);
        #1;
        acc = 1'b0;
        if (bus.Flush) begin
            exp_q.delete();
        end else if (bus.In_Valid && bus.In_Ready) begin
            exp_q.push_back(model(bus.Read_Reg_Data_1, bus.Read_Reg_Data_2, bus.Branch_Pc,
                                  bus.Branch_Imm, bus.Branch_Funct3, bus.Pred_Taken));
            acc = 1'b1;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic [12:0] imm, input logic [2:0] f3, input logic pred);
        bit acc;
        acc = 1'b0;
        bus.In_Valid        = 1'b1;
        bus.Read_Reg_Data_1 = a;
        bus.Read_Reg_Data_2 = b;
        bus.Branch_Pc       = pc;
        bus.Branch_Imm      = imm;
        bus.Branch_Funct3   = f3;
        bus.Pred_Taken      = pred;
        for (int n = 0; n < 200; n++) begin
            step(acc);
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'(1));
        bus.In_Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        bus.In_Valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic flush_cycle(input logic with_req);
        bit acc;
        bus.Flush           = 1'b1;
        bus.In_Valid        = with_req;
        bus.Read_Reg_Data_1 = $urandom;
        bus.Read_Reg_Data_2 = $urandom;
        bus.Branch_Funct3   = 3'($urandom);
        step(acc);
        bus.Flush    = 1'b0;
        bus.In_Valid = 1'b0;
        chk("flush_out_valid", 64'(bus.Out_Valid), 64'(0));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.Out_Valid),      64'(0));
        chk({tag, "_taken"},     64'(bus.Branch_Taken),   64'(0));
        chk({tag, "_target"},    64'(bus.Branch_Target),  64'(0));
        chk({tag, "_misp"},      64'(bus.Mispredict),     64'(0));
        chk({tag, "_illegal"},   64'(bus.Illegal_Funct3), 64'(0));
`ifdef BRANCH_STATS_EN
        chk({tag, "_stat_br"},   64'(bus.Stat_Branches),    64'(0));
        chk({tag, "_stat_tk"},   64'(bus.Stat_Taken),       64'(0));
        chk({tag, "_stat_mp"},   64'(bus.Stat_Mispredicts), 64'(0));
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          r;

        Reset_n             = 1'b0;
        bus.Flush           = 1'b0;
        bus.In_Valid        = 1'b0;
        bus.Read_Reg_Data_1 = '0;
        bus.Read_Reg_Data_2 = '0;
        bus.Branch_Pc       = '0;
        bus.Branch_Imm      = '0;
        bus.Branch_Funct3   = '0;
        bus.Pred_Taken      = 1'b0;
        bus.Out_Ready       = 1'b1;

        repeat (2) @(posedge Clk);
        #1;
        check_zero_outputs("reset");
        #2 Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("in_ready_after_reset", 64'(bus.In_Ready), 64'(1));

        // Signed versus unsigned compares.
        send(32'hFFFF_FFFF, 32'h1, 32'h100, 13'h10, 3'd4, 1'b0);
        send(32'hFFFF_FFFF, 32'h1, 32'h100, 13'h10, 3'd6, 1'b0);
        send(32'hFFFF_FFFF, 32'h1, 32'h100, 13'h10, 3'd5, 1'b0);
        send(32'hFFFF_FFFF, 32'h1, 32'h100, 13'h10, 3'd7, 1'b0);
        send(32'h8000_0000, 32'h0, 32'h100, 13'h10, 3'd4, 1'b1);

        // Target and mispredict.
        send(32'd5, 32'd5, 32'h1000, 13'h1FF0, 3'd0, 1'b0);
        send(32'd5, 32'd5, 32'h1000, 13'h1FF0, 3'd1, 1'b0);

        // Illegal funct3 and address wrap.
        send(32'd1, 32'd2, 32'h2000, 13'h40, 3'd2, 1'b1);
        send(32'd1, 32'd2, 32'h2000, 13'h40, 3'd3, 1'b0);
        send(32'd7, 32'd7, 32'hFFFF_FFFC, 13'h40, 3'd1, 1'b0);
        send(32'd7, 32'd7, 32'hFFFF_FFF0, 13'h20, 3'd0, 1'b1);
        idle(2);

        // Backpressure: three back-to-back requests against a stalled consumer.
        rdy_mode = 2;
        @(posedge Clk);
        #1;
        fork
            begin
                send(32'd1, 32'd1, 32'h3000, 13'h8,    3'd0, 1'b1);
                send(32'd1, 32'd2, 32'h3004, 13'h1FFC, 3'd6, 1'b0);
                send(32'd9, 32'd2, 32'h3008, 13'h100,  3'd5, 1'b0);
            end
            begin
                repeat (3) @(posedge Clk);
                rdy_mode = 0;
            end
        join
        idle(3);

        // Flush with a held result and a simultaneous request.
        rdy_mode = 2;
        @(posedge Clk);
        #1;
        send(32'd4, 32'd3, 32'h4000, 13'h20, 3'd4, 1'b0);
        idle(1);
        flush_cycle(1'b1);
        rdy_mode = 0;
        idle(2);

        // Reset while a result is held.
        rdy_mode = 2;
        @(posedge Clk);
        #1;
        send(32'd4, 32'd4, 32'h5000, 13'h20, 3'd0, 1'b1);
        Reset_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid");
        exp_q.delete();
        st_br = 0;
        st_tk = 0;
        st_mp = 0;
        rdy_mode = 0;
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("in_ready_after_reset_mid", 64'(bus.In_Ready), 64'(1));

        // Randomized traffic with random backpressure and occasional flushes.
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                flush_cycle(1'($urandom));
            end else if (r < 20) begin
                idle(1);
            end else begin
                a = $urandom;
                case ($urandom_range(0, 3))
                    0:       b = a;
                    1:       b = a ^ 32'h8000_0000;
                    default: b = $urandom;
                endcase
                send(a, b, $urandom, {12'($urandom), 1'b0}, 3'($urandom), 1'($urandom));
            end
        end

        rdy_mode = 0;
        idle(4);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
`ifdef BRANCH_STATS_EN
        chk("stat_branches",    64'(bus.Stat_Branches),    64'(st_br));
        chk("stat_taken",       64'(bus.Stat_Taken),       64'(st_tk));
        chk("stat_mispredicts", 64'(bus.Stat_Mispredicts), 64'(st_mp));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
